lcd_text_ctrl: RTL and testbench

Parametrised HD44780-style character-LCD controller. It replaces the fixed-message display driver with a host-writable character buffer of ROWS×COLS cells. It runs the power-up init sequence once, then refreshes the glass from the buffer, either continuously or on request. It sits between the measurement/formatting logic (which writes ASCII cells) and the LCD pins.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_tick_gen.sv | 24 ++
 rtl/lcd_text_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller: HD44780 command codes,
// controller state encoding and the row-to-DDRAM base address map.
package lcd_pkg;

  localparam logic [7:0] CMD_FSET_1L = 8'h30;
  localparam logic [7:0] CMD_FSET_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_PON,
    ST_INIT0,
    ST_INIT1,
    ST_INIT2,
    ST_INIT3,
    ST_CLRW,
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FEND
  } lcd_state_e;

  // Rows 2 and 3 continue lines 0 and 1 in DDRAM, offset by the row length.
  function automatic logic [7:0] row_base(input logic [1:0] row, input int unsigned cols);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(cols);
      default: return 8'h40 + 8'(cols);
    endcase
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider producing a one-clk tick enable every TICK_DIV clocks.
module lcd_tick_gen #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780-style text LCD controller: runs the init sequence once, then paints
// the host-written ROWS x COLS character buffer continuously or on request.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 2,
  parameter int unsigned PON_WAIT = 8,
  parameter int unsigned CLR_WAIT = 4,
  parameter int unsigned AW       = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          cont_mode,
  input  logic          refresh_req,
  output logic          busy,
  output logic          frame_done,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_dat,
  output logic          lcd_bl_p,
  output logic          lcd_bl_n
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam logic [7:0]  FSET  = (ROWS > 1) ? CMD_FSET_2L : CMD_FSET_1L;

  logic tick;

  lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick)
  );

  logic [7:0]    cell_q [NCELL];
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;

  // Read-first: a write in the same clk as the tick-0 read lands after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCELL; i++) cell_q[i] <= ASCII_SPACE;
    end else if (wr_en && (32'(wr_addr) < NCELL)) begin
      cell_q[IW'(wr_addr)] <= wr_data;
    end
  end

  lcd_state_e  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] wait_q, wait_d;
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        pend_q, pend_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic [7:0]  dat_q, dat_d;

  logic        is_byte;
  logic        byte_rs;
  logic [7:0]  byte_val;

  always_comb begin
    rd_idx  = IW'(32'(row_q) * COLS + 32'(col_q));
    rd_data = cell_q[rd_idx];
  end

  always_comb begin
    is_byte  = 1'b1;
    byte_rs  = 1'b0;
    byte_val = '0;
    case (state_q)
      ST_INIT0: byte_val = FSET;
      ST_INIT1: byte_val = CMD_DISP_ON;
      ST_INIT2: byte_val = CMD_ENTRY;
      ST_INIT3: byte_val = CMD_CLEAR;
      ST_ADDR:  byte_val = CMD_DDRAM | row_base(row_q, COLS);
      ST_DATA: begin
        byte_val = rd_data;
        byte_rs  = 1'b1;
      end
      default:  is_byte = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    row_d   = row_q;
    col_d   = col_q;
    pend_d  = pend_q;
    rs_d    = rs_q;
    en_d    = en_q;
    dat_d   = dat_q;

    if (state_q == ST_IDLE && refresh_req) pend_d = 1'b1;

    // FEND lasts exactly one clk, independent of the tick.
    if (state_q == ST_FEND) begin
      state_d = ST_IDLE;
    end else if (tick) begin
      if (is_byte) begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0: begin
            rs_d  = byte_rs;
            dat_d = byte_val;
            en_d  = 1'b0;
          end
          2'd1, 2'd2: en_d = 1'b1;
          default: begin
            en_d = 1'b0;
            case (state_q)
              ST_INIT0: state_d = ST_INIT1;
              ST_INIT1: state_d = ST_INIT2;
              ST_INIT2: state_d = ST_INIT3;
              ST_INIT3: begin
                state_d = ST_CLRW;
                wait_d  = '0;
              end
              ST_ADDR: begin
                state_d = ST_DATA;
                col_d   = '0;
              end
              default: begin
                if (32'(col_q) == COLS - 1) begin
                  col_d = '0;
                  if (32'(row_q) == ROWS - 1) begin
                    state_d = ST_FEND;
                  end else begin
                    row_d   = row_q + 2'd1;
                    state_d = ST_ADDR;
                  end
                end else begin
                  col_d = col_q + 6'd1;
                end
              end
            endcase
          end
        endcase
      end else begin
        case (state_q)
          ST_PON: begin
            if (32'(wait_q) + 32'd1 >= PON_WAIT) begin
              state_d = ST_INIT0;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + 16'd1;
            end
          end
          ST_CLRW: begin
            if (32'(wait_q) + 32'd1 >= CLR_WAIT) begin
              state_d = ST_IDLE;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + 16'd1;
            end
          end
          ST_IDLE: begin
            if (cont_mode || pend_q || refresh_req) begin
              state_d = ST_ADDR;
              row_d   = '0;
              phase_d = '0;
              pend_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PON;
      phase_q <= '0;
      wait_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pend_q  <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pend_q  <= pend_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_FEND);
    lcd_rs     = rs_q;
    lcd_en     = en_q;
    lcd_dat    = dat_q;
    lcd_rw     = 1'b0;
    lcd_bl_p   = 1'b1;
    lcd_bl_n   = 1'b0;
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl: a 2x16 instance (6-bit address) and a 4x20 instance.
module tb_lcd_text_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, wr_en_a, cont_a, req_a;
  logic [5:0] addr_a;
  logic [7:0] wdat_a;
  logic       busy_a, fd_a, rs_a, rw_a, en_a, blp_a, bln_a;
  logic [7:0] dat_a;

  logic       rst_b, wr_en_b, cont_b, req_b;
  logic [6:0] addr_b;
  logic [7:0] wdat_b;
  logic       busy_b, fd_b, rs_b, rw_b, en_b, blp_b, bln_b;
  logic [7:0] dat_b;

  lcd_text_ctrl #(.TICK_DIV(4), .COLS(16), .ROWS(2), .PON_WAIT(8), .CLR_WAIT(4), .AW(6)) dut_a (
    .clk(clk), .reset(rst_a), .wr_en(wr_en_a), .wr_addr(addr_a), .wr_data(wdat_a),
    .cont_mode(cont_a), .refresh_req(req_a), .busy(busy_a), .frame_done(fd_a),
    .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_en(en_a), .lcd_dat(dat_a),
    .lcd_bl_p(blp_a), .lcd_bl_n(bln_a)
  );

  lcd_text_ctrl #(.TICK_DIV(4), .COLS(20), .ROWS(4)) dut_b (
    .clk(clk), .reset(rst_b), .wr_en(wr_en_b), .wr_addr(addr_b), .wr_data(wdat_b),
    .cont_mode(cont_b), .refresh_req(req_b), .busy(busy_b), .frame_done(fd_b),
    .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_en(en_b), .lcd_dat(dat_b),
    .lcd_bl_p(blp_b), .lcd_bl_n(bln_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor: every en rising edge logs {rs,dat}; en-high widths for instance A.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int         la[$];
  int         hi_a = 0;
  logic       pa = 1'b0, pb = 1'b0;
  int         fd_cnt_a = 0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (en_a && !pa) qa.push_back({rs_a, dat_a});
    if (en_a) hi_a++;
    else if (pa) begin
      la.push_back(hi_a);
      hi_a = 0;
    end
    pa = en_a;
    if (fd_a) fd_cnt_a++;
    if (en_b && !pb) qb.push_back({rs_b, dat_b});
    pb = en_b;
  end

  logic [7:0] mem_a [32];
  logic [8:0] init_exp [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
  logic [8:0] base_b [4]   = '{9'h080, 9'h0C0, 9'h094, 9'h0D4};

  task automatic count_busy_a(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy_a) break;
    end
  endtask

  task automatic check_init_a(input string tag);
    chk({tag, "_nbytes"}, qa.size(), 4);
    chk({tag, "_nstrobes"}, la.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa.size()) chk($sformatf("%s_byte%0d", tag, i), qa[i], init_exp[i]);
      if (i < la.size()) chk($sformatf("%s_en_clks%0d", tag, i), la[i], 8);
    end
  endtask

  task automatic write_a(input logic [5:0] a, input logic [7:0] d);
    wr_en_a = 1'b1;
    addr_a  = a;
    wdat_a  = d;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic pulse_req(input bit which_b);
    if (which_b) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic wait_fd(input bit which_b, input int max_clks, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_clks; i++) begin
      @(negedge clk);
      if (which_b ? fd_b : fd_a) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame_a(input string tag);
    chk({tag, "_nbytes"}, qa.size(), 34);
    if (qa.size() == 34) begin
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("%s_addr_r%0d", tag, r), qa[r*17], (r == 0) ? 9'h080 : 9'h0C0);
        for (int c = 0; c < 16; c++)
          chk($sformatf("%s_r%0d_c%0d", tag, r, c), qa[r*17+1+c], {1'b1, mem_a[r*16+c]});
      end
    end
  endtask

  task automatic wait_en_rises_a(input int target, output int rises);
    logic prev;
    prev  = en_a;
    rises = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (en_a && !prev) rises++;
      prev = en_a;
      if (rises == target) break;
    end
  endtask

  initial begin
    bit seen;
    int n, t1, t2, fdc, rises;

    rst_a = 1'b1; wr_en_a = 1'b0; cont_a = 1'b0; req_a = 1'b0; addr_a = '0; wdat_a = '0;
    rst_b = 1'b1; wr_en_b = 1'b0; cont_b = 1'b0; req_b = 1'b0; addr_b = '0; wdat_b = '0;
    repeat (2) @(negedge clk);
    qa.delete(); qb.delete(); la.delete();
    @(negedge clk);

    chk("rst_en", en_a, 0);
    chk("rst_rs", rs_a, 0);
    chk("rst_dat", dat_a, 8'h00);
    chk("rst_busy", busy_a, 1);
    chk("rst_fd", fd_a, 0);
    chk("rst_rw", rw_a, 0);
    chk("rst_bl", {blp_a, bln_a}, 2'b10);
    chk("rst_busy_b", busy_b, 1);

    foreach (mem_a[i]) mem_a[i] = 8'h20;
    rst_a = 1'b0;
    rst_b = 1'b0;
    count_busy_a(n);
    chk("init_busy_clks", n, 112);
    check_init_a("init");
    chk("idle_en", en_a, 0);

    // "HI" on row 0, "OK" on row 1, single refresh
    write_a(6'd0, "H"); mem_a[0]  = "H";
    write_a(6'd1, "I"); mem_a[1]  = "I";
    write_a(6'd16, "O"); mem_a[16] = "O";
    write_a(6'd17, "K"); mem_a[17] = "K";
    qa.delete();
    fdc = fd_cnt_a;
    pulse_req(1'b0);
    wait_fd(1'b0, 4000, seen);
    chk("f1_done_seen", seen, 1);
    @(negedge clk);
    chk("f1_done_width", fd_a, 0);
    check_frame_a("f1");
    repeat (700) @(negedge clk);
    chk("f1_single_done", fd_cnt_a - fdc, 1);
    chk("f1_idle_busy", busy_a, 0);

    // continuous refresh period
    cont_a = 1'b1;
    wait_fd(1'b0, 4000, seen);
    chk("cont_done1", seen, 1);
    t1 = cyc;
    wait_fd(1'b0, 4000, seen);
    chk("cont_done2", seen, 1);
    t2 = cyc;
    cont_a = 1'b0;
    chk("cont_period_clks", t2 - t1, 548);
    @(negedge clk);
    fdc = fd_cnt_a;
    repeat (700) @(negedge clk);
    chk("cont_stopped", fd_cnt_a - fdc, 0);
    chk("cont_idle_busy", busy_a, 0);

    // out-of-range write, then a write colliding with the tick-0 read of cell 5
    write_a(6'd40, "Q");
    qa.delete();
    pulse_req(1'b0);
    wait_en_rises_a(6, rises);
    chk("rf_col4_found", rises, 6);
    repeat (11) @(negedge clk);
    wr_en_a = 1'b1; addr_a = 6'd5; wdat_a = "Z";
    @(negedge clk);
    wr_en_a = 1'b0;
    wait_fd(1'b0, 4000, seen);
    chk("rf_done_seen", seen, 1);
    chk("rf_cur_nbytes", qa.size(), 34);
    if (qa.size() == 34) chk("rf_cur_cell5", qa[6], 9'h120);
    mem_a[5] = "Z";
    @(negedge clk);
    qa.delete();
    pulse_req(1'b0);
    wait_fd(1'b0, 4000, seen);
    chk("f2_done_seen", seen, 1);
    check_frame_a("f2");

    // reset in the middle of row 1, col 7
    @(negedge clk);
    qa.delete();
    pulse_req(1'b0);
    wait_en_rises_a(26, rises);
    chk("mid_r1c7_found", rises, 26);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", en_a, 0);
    chk("mid_rst_rs", rs_a, 0);
    chk("mid_rst_dat", dat_a, 8'h00);
    chk("mid_rst_busy", busy_a, 1);
    chk("mid_rst_fd", fd_a, 0);
    @(negedge clk);
    qa.delete(); la.delete();
    @(negedge clk);
    rst_a = 1'b0;
    foreach (mem_a[i]) mem_a[i] = 8'h20;
    count_busy_a(n);
    chk("reinit_busy_clks", n, 112);
    check_init_a("reinit");
    qa.delete();
    pulse_req(1'b0);
    wait_fd(1'b0, 4000, seen);
    chk("f3_done_seen", seen, 1);
    check_frame_a("f3");

    // 4x20 instance: function set and row base addresses
    chk("b_init_nbytes", qb.size(), 4);
    if (qb.size() >= 1) chk("b_fset", qb[0], 9'h038);
    chk("b_idle_busy", busy_b, 0);
    qb.delete();
    pulse_req(1'b1);
    wait_fd(1'b1, 4000, seen);
    chk("b_done_seen", seen, 1);
    chk("b_nbytes", qb.size(), 84);
    if (qb.size() == 84) begin
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("b_addr_r%0d", r), qb[r*21], base_b[r]);
        for (int c = 0; c < 20; c++)
          chk($sformatf("b_r%0d_c%0d", r, c), qb[r*21+1+c], 9'h120);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
